// File: rtl/palette_lookup_arbiter.sv
// Purpose: round-robin share of one combinational sprite palette ROM among NUM_REQ pixel requesters.
// Latency: response strobe two clocks after the grant cycle; one accept per clock, sustained.
// Backpressure: none downstream; a requester holds req/index until its grant edge (may drop early).
module palette_lookup_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  IDX_W   = 5,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*IDX_W-1:0] req_index_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [IDX_W-1:0]         pal_index_o,
    input  logic [3:0]               pal_red_i,
    input  logic [3:0]               pal_green_i,
    input  logic [3:0]               pal_blue_i,
    output logic                     rsp_valid_o,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [11:0]              rsp_rgb_o,
    output logic                     rsp_opaque_o,
    output logic                     busy_o
);

    // Response payload travelling out of stage 2.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [11:0]     rgb;
        logic            opaque;
    } rsp_t;

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    // Round-robin pointer: requester that has first claim this cycle.
    logic [ID_W-1:0]  ptr_q, ptr_d;

    // Stage 1: index presented to the ROM, tagged with the requester.
    logic             s1_vld_q, s1_vld_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic [IDX_W-1:0] pal_index_q, pal_index_d;

    // Stage 2: registered ROM result.
    logic             rsp_vld_q, rsp_vld_d;
    rsp_t             rsp_q, rsp_d;

    // Arbitration results.
    logic             gnt_hit;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W:0]    cand;

    // Per-requester view of the packed index bus.
    logic [IDX_W-1:0] idx_arr [NUM_REQ];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign idx_arr[g] = req_index_i[g*IDX_W +: IDX_W];
        end
    endgenerate

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ; first one asking wins.
    always_comb begin
        gnt_hit = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!gnt_hit && req_i[cand[ID_W-1:0]]) begin
                gnt_hit = 1'b1;
                gnt_id  = cand[ID_W-1:0];
            end
        end
        // Nothing is accepted while reset is held, even if requests are present.
        if (reset_i) begin
            gnt_hit = 1'b0;
        end
    end

    assign grant_o = gnt_hit ? (NUM_REQ'(1) << gnt_id) : '0;

    // Next state for the pointer and stage 1: advance past the winner, latch its index.
    always_comb begin
        ptr_d       = ptr_q;
        s1_vld_d    = gnt_hit;
        s1_id_d     = s1_id_q;
        pal_index_d = pal_index_q;
        if (gnt_hit) begin
            ptr_d       = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
            s1_id_d     = gnt_id;
            pal_index_d = idx_arr[gnt_id];
        end
    end

    // Next state for stage 2: capture the ROM output; payload holds when nothing is in flight.
    always_comb begin
        rsp_vld_d = s1_vld_q;
        rsp_d     = rsp_q;
        if (s1_vld_q) begin
            rsp_d.id     = s1_id_q;
            rsp_d.rgb    = {pal_red_i, pal_green_i, pal_blue_i};
            rsp_d.opaque = (pal_index_q != '0);
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_id_q     <= '0;
            pal_index_q <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_vld_q    <= s1_vld_d;
            s1_id_q     <= s1_id_d;
            pal_index_q <= pal_index_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_q       <= rsp_d;
        end
    end

    assign pal_index_o  = pal_index_q;
    assign rsp_valid_o  = rsp_vld_q;
    assign rsp_id_o     = rsp_q.id;
    assign rsp_rgb_o    = rsp_q.rgb;
    assign rsp_opaque_o = rsp_q.opaque;
    assign busy_o       = s1_vld_q | rsp_vld_q;

    // Grant is at most one-hot and only ever goes to a requester that is asking.
    a_grant_onehot: assert property (@(posedge clk_i) $onehot0(grant_o));
    a_grant_req:    assert property (@(posedge clk_i) (grant_o & ~req_i) == '0);

endmodule
